// File: rtl/arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state, transaction owner,
// and the width of the fetch starvation counter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around mem_arbiter.
// slave = arbiter side, master = stages plus memory model side.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             IReqF_i;
  logic [WIDTH-1:0] IAddrF_i;
  logic             IGntF_o;
  logic             IValidF_o;
  logic [WIDTH-1:0] IRdataF_o;
  logic             DReqM_i;
  logic             DWeM_i;
  logic [WIDTH-1:0] DAddrM_i;
  logic [WIDTH-1:0] DWdataM_i;
  logic             DGntM_o;
  logic             DValidM_o;
  logic [WIDTH-1:0] DRdataM_o;
  logic             MemReq_o;
  logic             MemWe_o;
  logic [WIDTH-1:0] MemAddr_o;
  logic [WIDTH-1:0] MemWdata_o;
  logic             MemReady_i;
  logic             MemRvalid_i;
  logic [WIDTH-1:0] MemRdata_i;
  logic             StallF_o;

  modport slave (
    input  IReqF_i, IAddrF_i, DReqM_i, DWeM_i, DAddrM_i, DWdataM_i,
           MemReady_i, MemRvalid_i, MemRdata_i,
    output IGntF_o, IValidF_o, IRdataF_o, DGntM_o, DValidM_o, DRdataM_o,
           MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, StallF_o
  );

  modport master (
    output IReqF_i, IAddrF_i, DReqM_i, DWeM_i, DAddrM_i, DWdataM_i,
           MemReady_i, MemRvalid_i, MemRdata_i,
    input  IGntF_o, IValidF_o, IRdataF_o, DGntM_o, DValidM_o, DRdataM_o,
           MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, StallF_o
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while fetch waits; at_max tells the
// arbiter to let fetch win the next arbitration.
module arb_starve_cnt
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_reg;
  logic [STARVE_W-1:0] cnt_next;

  // Clear dominates; increment stops once the limit is reached.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg < LIMIT)) begin
      cnt_next = cnt_reg + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign at_max = (cnt_reg >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Optional grant/conflict statistics are enabled with `define ARB_STATS_EN.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   IGrantCnt_o,
  output logic [31:0]   DGrantCnt_o,
  output logic [31:0]   ConflictCnt_o
`endif
);

  arb_state_t state_reg, state_next;
  arb_owner_t owner_reg, owner_next;

  logic             idle;
  logic             d_win;
  logic             i_win;
  logic             mem_req;
  logic             i_grant;
  logic             d_grant;
  logic             rsp;
  logic             i_valid;
  logic             d_valid;
  logic             starve_at_max;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .clr    (i_grant || (idle && !bus.IReqF_i)),
    .inc    (d_grant && bus.IReqF_i),
    .at_max (starve_at_max)
  );

  // Everything request-side is qualified by rst so nothing leaks out while
  // reset is asserted.
  always_comb begin
    idle      = (state_reg == ARB_IDLE);
    d_win     = bus.DReqM_i && !(bus.IReqF_i && starve_at_max);
    i_win     = !d_win && bus.IReqF_i;
    mem_req   = rst && idle && (bus.IReqF_i || bus.DReqM_i);
    i_grant   = mem_req && bus.MemReady_i && i_win;
    d_grant   = mem_req && bus.MemReady_i && d_win;
    rsp       = rst && (state_reg == ARB_WAIT) && bus.MemRvalid_i;
    i_valid   = rsp && (owner_reg == OWN_I);
    d_valid   = rsp && (owner_reg == OWN_D);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (mem_req) begin
      if (d_win) begin
        mem_addr  = bus.DAddrM_i;
        mem_wdata = bus.DWdataM_i;
        mem_we    = bus.DWeM_i;
      end else begin
        mem_addr  = bus.IAddrF_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    if (idle) begin
      if (i_grant || d_grant) begin
        state_next = ARB_WAIT;
        owner_next = d_grant ? OWN_D : OWN_I;
      end
    end else if (rsp) begin
      state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWN_I;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end

  assign bus.MemReq_o   = mem_req;
  assign bus.MemWe_o    = mem_we;
  assign bus.MemAddr_o  = mem_addr;
  assign bus.MemWdata_o = mem_wdata;
  assign bus.IGntF_o    = i_grant;
  assign bus.DGntM_o    = d_grant;
  assign bus.IValidF_o  = i_valid;
  assign bus.DValidM_o  = d_valid;
  assign bus.IRdataF_o  = i_valid ? bus.MemRdata_i : '0;
  assign bus.DRdataM_o  = d_valid ? bus.MemRdata_i : '0;
  assign bus.StallF_o   = rst && bus.IReqF_i && !i_valid;

`ifdef ARB_STATS_EN
  logic [31:0] igrant_cnt_reg;
  logic [31:0] dgrant_cnt_reg;
  logic [31:0] conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      igrant_cnt_reg   <= '0;
      dgrant_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      if (i_grant) igrant_cnt_reg <= igrant_cnt_reg + 32'd1;
      if (d_grant) dgrant_cnt_reg <= dgrant_cnt_reg + 32'd1;
      if (idle && bus.IReqF_i && bus.DReqM_i && bus.MemReady_i) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
    end
  end

  assign IGrantCnt_o   = igrant_cnt_reg;
  assign DGrantCnt_o   = dgrant_cnt_reg;
  assign ConflictCnt_o = conflict_cnt_reg;
`endif

endmodule
